controlador_carga_instrucoes: RTL and testbench

Sequences the dual-port instruction memory, one clock domain. While the core is held in stall, it streams a program into the memory through write port B. It then reads the whole image back through port B and checks it with an XOR checksum. After a good check it releases the core, which fetches through port A (PC port). Sits between the boot/debug link, the core's fetch stage and memoria_instrucoes.

---
 rtl/controlador_carga_instrucoes_pkg.sv | 15 +
 rtl/controlador_carga_instrucoes_acumulador_checksum.sv | 24 ++
 rtl/controlador_carga_instrucoes.sv | 176 +++++++++++++++++
 tb/tb_controlador_carga_instrucoes.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_carga_instrucoes_pkg.sv
// Shared state encoding and default widths for the instruction loader.
package controlador_carga_instrucoes_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/controlador_carga_instrucoes_acumulador_checksum.sv
// XOR accumulator; clear wins over enable.
module acumulador_checksum
    import controlador_carga_instrucoes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sum
);

    // Running XOR of every enabled word since the last clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum ^ data;
        end
    end

endmodule

// File: rtl/controlador_carga_instrucoes.sv
// Loads a program image through memory port B, verifies it by XOR checksum
// readback, then releases the core to fetch through port A.
module controlador_carga_instrucoes
    import controlador_carga_instrucoes_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetch_en,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  core_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic                  mem_we_a,
    input  logic [DATA_WIDTH-1:0] mem_q_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [DATA_WIDTH-1:0] mem_data_b,
    output logic                  mem_we_b,
    input  logic [DATA_WIDTH-1:0] mem_q_b,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   pointer;
    logic                  rd_valid;
    logic                  clear;
    logic                  accept;
    logic                  rd_issue;
    logic [DATA_WIDTH-1:0] load_sum;
    logic [DATA_WIDTH-1:0] rb_sum;
    logic [DATA_WIDTH-1:0] rb_final;

    assign mem_addr_a = pc;
    assign mem_we_a   = 1'b0;
    assign instr      = instr_valid ? mem_q_a : '0;

    // The last readback word is folded in combinationally so the compare
    // happens in the same cycle it returns, keeping VERIFY at word_count+1.
    assign rb_final = rb_sum ^ (rd_valid ? mem_q_b : '0);

    acumulador_checksum #(.WIDTH(DATA_WIDTH)) u_sum_load (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (accept),
        .data   (load_data),
        .sum    (load_sum)
    );

    acumulador_checksum #(.WIDTH(DATA_WIDTH)) u_sum_leitura (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (rd_valid),
        .data   (mem_q_b),
        .sum    (rb_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and memory port B / handshake outputs.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        core_stall = 1'b1;
        mem_we_b   = 1'b0;
        mem_addr_b = '0;
        mem_data_b = '0;
        clear      = 1'b0;
        accept     = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    clear      = 1'b1;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept     = 1'b1;
                    mem_we_b   = 1'b1;
                    mem_addr_b = BASE + word_count[ADDR_WIDTH-1:0];
                    mem_data_b = load_data;
                    if (load_last) begin
                        state_next = ST_VERIFY;
                    end else if (word_count == LAST_SLOT) begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_VERIFY: begin
                if (pointer < word_count) begin
                    rd_issue   = 1'b1;
                    mem_addr_b = BASE + pointer[ADDR_WIDTH-1:0];
                end else if (rb_final == load_sum) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_ERROR;
                end
            end
            ST_RUN: begin
                core_stall = 1'b0;
                if (load_start) begin
                    state_next = ST_LOAD;
                    clear      = 1'b1;
                end
            end
            ST_ERROR: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    clear      = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters, readback pointer, status flags and fetch-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count  <= '0;
            pointer     <= '0;
            rd_valid    <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= fetch_en && (state == ST_RUN);
            rd_valid    <= rd_issue;
            if (clear) begin
                word_count <= '0;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else begin
                if (accept) begin
                    word_count <= word_count + 1'b1;
                end
                if (state == ST_VERIFY && state_next == ST_RUN) begin
                    load_done <= 1'b1;
                end
                if (state != ST_ERROR && state_next == ST_ERROR) begin
                    load_error <= 1'b1;
                end
            end
            if (state != ST_VERIFY) begin
                pointer <= '0;
            end else if (rd_issue) begin
                pointer <= pointer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_carga_instrucoes.sv
// Directed bench: default-size loader with a memory model, plus a 3-bit
// address instance for the overflow case.
module tb_controlador_carga_instrucoes;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic verifica(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- default instance (ADDR_WIDTH=12) ----------------
    logic        load_start = 0, load_valid = 0, load_last = 0, fetch_en = 0;
    logic [31:0] load_data = '0;
    logic [11:0] pc = '0;
    logic        load_ready, instr_valid, core_stall, mem_we_a, mem_we_b;
    logic        load_done, load_error;
    logic [31:0] instr, mem_q_a, mem_q_b, mem_data_b;
    logic [11:0] mem_addr_a, mem_addr_b;
    logic [12:0] word_count;

    controlador_carga_instrucoes dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .pc(pc), .fetch_en(fetch_en), .instr(instr), .instr_valid(instr_valid),
        .core_stall(core_stall), .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a),
        .mem_q_a(mem_q_a), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
        .mem_we_b(mem_we_b), .mem_q_b(mem_q_b), .word_count(word_count),
        .load_done(load_done), .load_error(load_error)
    );

    logic [31:0] mem [0:4095];
    logic        corrupt_req = 1'b0;
    always @(posedge clk) begin
        if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
        if (corrupt_req) mem[1] <= 32'hDEADBEEF;
        mem_q_a <= mem[mem_addr_a];
        mem_q_b <= mem[mem_addr_b];
    end

    // ---------------- small instance (ADDR_WIDTH=3) ----------------
    logic        s_load_start = 0, s_load_valid = 0, s_load_last = 0;
    logic [31:0] s_load_data = '0;
    logic [2:0]  s_pc = '0;
    logic        s_load_ready, s_instr_valid, s_core_stall, s_mem_we_a, s_mem_we_b;
    logic        s_load_done, s_load_error;
    logic [31:0] s_instr, s_mem_q_a, s_mem_q_b, s_mem_data_b;
    logic [2:0]  s_mem_addr_a, s_mem_addr_b;
    logic [3:0]  s_word_count;

    controlador_carga_instrucoes #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BASE_ADDR(0)) dut_s (
        .clk(clk), .reset(reset), .load_start(s_load_start), .load_valid(s_load_valid),
        .load_data(s_load_data), .load_last(s_load_last), .load_ready(s_load_ready),
        .pc(s_pc), .fetch_en(1'b0), .instr(s_instr), .instr_valid(s_instr_valid),
        .core_stall(s_core_stall), .mem_addr_a(s_mem_addr_a), .mem_we_a(s_mem_we_a),
        .mem_q_a(s_mem_q_a), .mem_addr_b(s_mem_addr_b), .mem_data_b(s_mem_data_b),
        .mem_we_b(s_mem_we_b), .mem_q_b(s_mem_q_b), .word_count(s_word_count),
        .load_done(s_load_done), .load_error(s_load_error)
    );

    logic [31:0] smem [0:7];
    always @(posedge clk) begin
        if (s_mem_we_b) smem[s_mem_addr_b] <= s_mem_data_b;
        s_mem_q_a <= smem[s_mem_addr_a];
        s_mem_q_b <= smem[s_mem_addr_b];
    end

    logic [31:0] vec [0:3];

    // Streams n beats of vec; optionally corrupts addr 1 during VERIFY,
    // inserts a two-cycle gap before beat gap_at, and waits for the verdict.
    task automatic do_load(input bit send_start, input int n, input bit final_last,
                           input bit corrupt, input int gap_at, output int vcycles);
        vcycles = 0;
        if (send_start) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
        end
        verifica("load_ready_in_load", load_ready, 1);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                load_valid = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    #1;
                    verifica("gap_no_write", mem_we_b, 0);
                    verifica("gap_word_count", word_count, 64'(i));
                    @(negedge clk);
                end
            end
            load_valid = 1'b1;
            load_data  = vec[i];
            load_last  = final_last && (i == n - 1);
            #1;
            verifica("beat_we", mem_we_b, 1);
            verifica("beat_addr", mem_addr_b, 64'(i));
            verifica("beat_data", mem_data_b, vec[i]);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (final_last) begin
            corrupt_req = corrupt;
            while (!load_done && !load_error && vcycles < 50) begin
                @(negedge clk);
                corrupt_req = 1'b0;
                vcycles++;
            end
            corrupt_req = 1'b0;
        end
    endtask

    int vc;

    initial begin
        @(negedge clk);
        @(negedge clk);
        verifica("rst_word_count", word_count, 0);
        verifica("rst_load_ready", load_ready, 0);
        verifica("rst_core_stall", core_stall, 1);
        verifica("rst_load_done", load_done, 0);
        verifica("rst_load_error", load_error, 0);
        verifica("rst_instr_valid", instr_valid, 0);
        verifica("rst_instr", instr, 0);
        verifica("rst_mem_we_b", mem_we_b, 0);
        reset = 1'b0;
        @(negedge clk);
        verifica("idle_stall", core_stall, 1);

        // Good 4-word load
        vec[0] = 32'h11111111; vec[1] = 32'h22222222;
        vec[2] = 32'h44444444; vec[3] = 32'h88888888;
        do_load(1, 4, 1, 0, -1, vc);
        verifica("verify_cycles", vc, 5);
        verifica("good_load_done", load_done, 1);
        verifica("good_load_error", load_error, 0);
        verifica("good_word_count", word_count, 4);
        verifica("good_core_stall", core_stall, 0);
        verifica("mem_word3", mem[3], 32'h88888888);

        // Fetch in RUN
        pc = 12'd2; fetch_en = 1'b1;
        #1 verifica("addr_a", mem_addr_a, 2);
        verifica("we_a", mem_we_a, 0);
        @(negedge clk);
        fetch_en = 1'b0;
        verifica("fetch_valid", instr_valid, 1);
        verifica("fetch_instr", instr, 32'h44444444);
        @(negedge clk);
        verifica("fetch_idle_valid", instr_valid, 0);

        // load_start together with fetch: fetch still completes, then LOAD
        pc = 12'd0; fetch_en = 1'b1; load_start = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; load_start = 1'b0;
        verifica("simul_valid", instr_valid, 1);
        verifica("simul_instr", instr, 32'h11111111);
        verifica("simul_core_stall", core_stall, 1);
        verifica("simul_load_done_cleared", load_done, 0);
        @(negedge clk);
        verifica("simul_valid_drop", instr_valid, 0);

        // Same image, corrupted during VERIFY -> ERROR
        do_load(0, 4, 1, 1, -1, vc);
        verifica("bad_verify_cycles", vc, 5);
        verifica("bad_load_error", load_error, 1);
        verifica("bad_load_done", load_done, 0);
        verifica("bad_core_stall", core_stall, 1);
        verifica("bad_load_ready", load_ready, 0);
        load_valid = 1'b1;
        #1 verifica("err_ignores_valid", mem_we_b, 0);
        @(negedge clk);
        load_valid = 1'b0;
        verifica("err_sticky", load_error, 1);

        // Fresh load with a mid-load gap recovers
        do_load(1, 4, 1, 0, 2, vc);
        verifica("reload_done", load_done, 1);
        verifica("reload_error", load_error, 0);
        verifica("reload_mem1", mem[1], 32'h22222222);

        // Reset after 2 of 4 beats
        vec[0] = 32'hAAAAAAAA; vec[1] = 32'hBBBBBBBB;
        do_load(1, 2, 0, 0, -1, vc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        verifica("midrst_word_count", word_count, 0);
        verifica("midrst_load_ready", load_ready, 0);
        verifica("midrst_core_stall", core_stall, 1);
        verifica("midrst_load_done", load_done, 0);
        verifica("midrst_mem0", mem[0], 32'hAAAAAAAA);
        verifica("midrst_mem1", mem[1], 32'hBBBBBBBB);
        verifica("midrst_mem2", mem[2], 32'h44444444);

        // Overflow on the 3-bit instance
        s_load_start = 1'b1;
        @(negedge clk);
        s_load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = 32'h100 + 32'(i);
            #1;
            verifica("ovf_we", s_mem_we_b, 1);
            verifica("ovf_addr", s_mem_addr_b, 64'(i));
            @(negedge clk);
        end
        verifica("ovf_error", s_load_error, 1);
        verifica("ovf_ready", s_load_ready, 0);
        verifica("ovf_word_count", s_word_count, 8);
        verifica("ovf_stall", s_core_stall, 1);
        verifica("ovf_done", s_load_done, 0);
        #1 verifica("ovf_9th_no_write", s_mem_we_b, 0);
        @(negedge clk);
        s_load_valid = 1'b0;
        verifica("ovf_smem0", smem[0], 32'h100);
        verifica("ovf_smem7", smem[7], 32'h107);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
